sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Bridges the MEM stage's 32-bit data-memory requests to an external asynchronous 16-bit SRAM (256K x 16).
- Each 32-bit access is split into two 16-bit half-accesses: low half first, then high half.
- Sits directly downstream of the MEM stage.
- Drops `ready` while an access is in flight; the top level uses `~ready` as a pipeline freeze alongside the hazard freeze.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- ACCESS_CYCLES, 3: clock cycles spent on each 16-bit half-access (minimum 2).
- SRAM_ADDR_W, 18: SRAM address bus width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- MEM_r_en  input  1  load request from MEM stage.
- MEM_w_en  input  1  store request from MEM stage.
- address  input  32  byte address (ALU result); word-aligned.
- write_data  input  32  store data (val_rm).
- read_data  output  32  load result, valid while ready=1 in DONE.
- ready  output  1  0 = stall the pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  SRAM_ADDR_W  SRAM word address.
- SRAM_WE_N  output  1  write enable, active-low.
- SRAM_OE_N  output  1  output enable, active-low.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied 0 (chip and both bytes always selected).

Behaviour:
- **Reset** (rst=0, asynchronous):
  - state=IDLE, counter=0, read_data=0.
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, SRAM_DQ=Z.
  - ready=1 once in IDLE with no request.
  - Reset mid-access aborts immediately: WE_N deasserts and DQ releases asynchronously, and no partial result is kept.
- **Address map:** word = (address - BASE_ADDR) >> 2, truncated. SRAM_ADDR = {word[SRAM_ADDR_W-2:0], half}, where half=0 for LOW and 1 for HIGH. address[1:0] is ignored.
- **States:** IDLE, LOW, HIGH, DONE.
- **IDLE:**
  - ready = ~(MEM_r_en | MEM_w_en), combinational.
  - A request moves to LOW and latches the operation: write if MEM_w_en=1, otherwise read.
  - If both enables are set, write wins.
- **LOW / HIGH:**
  - counter runs 0..ACCESS_CYCLES-1; at the last count it resets and the state advances (LOW→HIGH, HIGH→DONE).
  - Write:
    - DQ is driven with write_data[15:0] in LOW and write_data[31:16] in HIGH for every cycle of the half.
    - WE_N=0 for counts 0..ACCESS_CYCLES-2 and 1 on the last count (data hold), so each half gets exactly ACCESS_CYCLES-1 WE_N-low cycles.
    - OE_N=1.
  - Read:
    - DQ=Z, OE_N=0, WE_N=1.
    - On the last count's rising edge, DQ is latched into read_data[15:0] (LOW) or read_data[31:16] (HIGH).
  - ready=0 throughout.
- **DONE:** one cycle, ready=1, WE_N=OE_N=1, DQ=Z. Next state is IDLE unconditionally.
  - The pipeline advances on this edge, so the same request is never re-issued.
- **Latency:** request sampled in IDLE at cycle 0; ready=0 for cycles 0..2*ACCESS_CYCLES; ready=1 at cycle 2*ACCESS_CYCLES+1. Default: ready at cycle 7.
- **Stability:**
  - Inputs are held stable by the freeze for the whole access; the controller relatches nothing after IDLE.
  - Enable changes mid-access are ignored.
  - read_data holds its value until the next read's LOW latch.
- **Back-to-back:** a request present in IDLE right after DONE starts a new access with no extra bubble beyond the IDLE cycle.
- **Write-only effects:** stores never alter read_data.

Decomposition:
- Shared package holds:
  - the state encoding enum (IDLE, LOW, HIGH, DONE);
  - the BASE_ADDR default;
  - the SRAM width constants, shared with the SRAM behavioural model used by the bench.
- No sub-module is needed; counter and FSM live in one module.
- The top-level freeze becomes hazard | ~ready, applied to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Test Plan:
- **Reset:** assert rst=0 mid-read (state HIGH) → WE_N=1, OE_N=1, DQ=Z immediately. After release with no request, ready=1 and read_data=0.
- **Store:** address=1024, write_data=0xDEADBEEF, MEM_w_en=1 → SRAM word 0 = 0xBEEF and word 1 = 0xDEAD. Each word sees exactly 2 WE_N-low cycles. ready=0 for 7 cycles, then 1 at cycle 7.
- **Load after store:** MEM_r_en=1, address=1024 → read_data=0xDEADBEEF when ready rises at cycle 7. OE_N=0 in LOW and HIGH only.
- **Address map:** store 0x12345678 at address 1036 (word 3), i.e. SRAM_ADDR 6 and 7. Then load 1036 → 0x12345678, and a load of 1032 returns its own prior contents.
- **Conflict and back-to-back:** MEM_r_en=MEM_w_en=1 → a write is performed. A load issued in the cycle after DONE starts immediately, and its ready rises 8 cycles after the previous ready.
- **Idle transparency:** no enables for 20 cycles → ready stays 1, WE_N and OE_N stay 1, SRAM_ADDR is unchanged.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 32-bit to 16-bit asynchronous SRAM bridge.
// The width constants are also used by the bench's SRAM model.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;
    localparam int          SRAM_DATA_W         = 16;
    localparam int          SRAM_DEFAULT_ADDR_W = 18;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM half-accesses
// (low half first) and holds ready low while the access is in flight.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int          ACCESS_CYCLES = 3,
    parameter int          SRAM_ADDR_W   = SRAM_DEFAULT_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_r_en,
    input  logic                   MEM_w_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       counter_q, counter_d;
    logic                   is_write_q, is_write_d;
    logic [31:0]            read_data_q, read_data_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;

    logic [SRAM_ADDR_W-2:0] word_addr;
    logic                   last_cnt;
    logic                   dq_drive;
    logic [SRAM_DATA_W-1:0] dq_out;

    // Offset is truncated to the SRAM word range; the byte lane bits drop out in the shift.
    assign word_addr = (SRAM_ADDR_W-1)'((address - BASE_ADDR) >> 2);
    assign last_cnt  = (counter_q == LAST_CNT);

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        is_write_d  = is_write_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        ready       = 1'b0;
        SRAM_WE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        dq_drive    = 1'b0;
        dq_out      = write_data[15:0];

        case (state_q)
            IDLE: begin
                ready = ~(MEM_r_en | MEM_w_en);
                if (MEM_r_en || MEM_w_en) begin
                    state_d     = LOW;
                    counter_d   = '0;
                    is_write_d  = MEM_w_en;
                    sram_addr_d = {word_addr, 1'b0};
                end
            end
            LOW, HIGH: begin
                counter_d = last_cnt ? '0 : counter_q + 1'b1;
                if (is_write_q) begin
                    dq_drive  = 1'b1;
                    dq_out    = (state_q == HIGH) ? write_data[31:16] : write_data[15:0];
                    // WE_N rises on the last count so data is held past the write strobe.
                    SRAM_WE_N = last_cnt;
                end else begin
                    SRAM_OE_N = 1'b0;
                    if (last_cnt) begin
                        if (state_q == HIGH) read_data_d[31:16] = SRAM_DQ;
                        else                 read_data_d[15:0]  = SRAM_DQ;
                    end
                end
                if (last_cnt) begin
                    if (state_q == LOW) begin
                        state_d     = HIGH;
                        sram_addr_d = {word_addr, 1'b1};
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            is_write_q  <= 1'b0;
            read_data_q <= '0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            is_write_q  <= is_write_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    assign SRAM_DQ   = dq_drive ? dq_out : {SRAM_DATA_W{1'bz}};
    assign SRAM_ADDR = sram_addr_q;
    assign read_data = read_data_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed vector table, random traffic
// against a word-level reference model, idle and reset corner cases.
module tb_sram_controller;
    import sram_controller_pkg::*;

    localparam int AC          = 3;
    localparam int LATENCY     = 2 * AC + 1;
    localparam int MODEL_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    wire  [31:0] read_data;
    wire         ready;
    wire  [SRAM_DATA_W-1:0]         sram_dq;
    wire  [SRAM_DEFAULT_ADDR_W-1:0] sram_addr;
    wire         sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    sram_controller #(
        .BASE_ADDR     (DEFAULT_BASE_ADDR),
        .ACCESS_CYCLES (AC),
        .SRAM_ADDR_W   (SRAM_DEFAULT_ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_r_en   (mem_r_en),
        .MEM_w_en   (mem_w_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: writes while WE_N is low at each clock, drives the bus on reads.
    logic [SRAM_DATA_W-1:0] sram_mem [0:MODEL_WORDS-1] = '{default: '0};
    int                     we_cnt   [0:MODEL_WORDS-1] = '{default: 0};
    int                     we_total = 0;
    longint                 cyc = 0;

    assign sram_dq = (!sram_oe_n && sram_we_n) ? sram_mem[sram_addr[9:0]] : {SRAM_DATA_W{1'bz}};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && !sram_we_n) begin
            sram_mem[sram_addr[9:0]] <= sram_dq;
            we_cnt[sram_addr[9:0]]   <= we_cnt[sram_addr[9:0]] + 1;
            we_total                 <= we_total + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: 32-bit words indexed by (address-1024)/4, zero when never written.
    logic [31:0] ref_mem [int];
    logic [31:0] ref_last_read = 32'd0;
    longint      last_rise = -1;

    function automatic logic [31:0] ref_read(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'd0;
    endfunction

    task automatic run_access(input bit r, input bit w, input logic [31:0] a,
                              input logic [31:0] wd, input string tag);
        int          lat;
        int          oe_low;
        int          we0;
        int          word;
        logic [SRAM_DEFAULT_ADDR_W-1:0] a_lo;
        logic [SRAM_DEFAULT_ADDR_W-1:0] a_hi;
        a_lo = '0;
        a_hi = '0;
        @(posedge clk); #1;
        mem_r_en = r; mem_w_en = w; address = a; write_data = wd;
        we0 = we_total; oe_low = 0; lat = 0;
        @(negedge clk);
        while (!ready && lat < 50) begin
            if (!sram_oe_n) oe_low++;
            if (lat == 1)      a_lo = sram_addr;
            if (lat == AC + 1) a_hi = sram_addr;
            lat++;
            @(negedge clk);
        end
        if (!sram_oe_n) oe_low++;
        word = int'((a - 32'd1024) >> 2);
        check({tag, " latency"}, 64'(lat), 64'(LATENCY));
        check({tag, " addr_low"}, 64'(a_lo), 64'(word * 2));
        check({tag, " addr_high"}, 64'(a_hi), 64'(word * 2 + 1));
        check({tag, " oe_low_cycles"}, 64'(oe_low), w ? 64'd0 : 64'(2 * AC));
        check({tag, " we_low_cycles"}, 64'(we_total - we0), w ? 64'(2 * (AC - 1)) : 64'd0);
        if (last_rise >= 0) check({tag, " ready_gap"}, 64'(cyc - last_rise), 64'(LATENCY + 1));
        last_rise = cyc;
        if (w) ref_mem[word] = wd;
        else   ref_last_read = ref_read(word);
        $display("txn %s r=%0d w=%0d addr=%0d wdata=%h read_data=%h latency=%0d",
                 tag, r, w, a, wd, read_data, lat);
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'd1036, 32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd1036, 32'h00000000, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'h00000000};
        vecs[5] = '{1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 32'h00000000};
        vecs[6] = '{1'b1, 1'b0, 32'd1040, 32'h00000000, 32'hCAFEF00D};
        vecs[7] = '{1'b0, 1'b1, 32'd1027, 32'hA5A55A5A, 32'hCAFEF00D};
        vecs[8] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'hA5A55A5A};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset we_n", 64'(sram_we_n), 64'd1);
        check("reset oe_n", 64'(sram_oe_n), 64'd1);
        check("reset addr", 64'(sram_addr), 64'd0);
        check("reset read_data", 64'(read_data), 64'd0);
        check("reset ready", 64'(ready), 64'd1);
        check("tied selects", 64'({sram_ce_n, sram_ub_n, sram_lb_n}), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("post-reset ready", 64'(ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            run_access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].wd, $sformatf("vec%0d", i));
            check($sformatf("vec%0d read_data", i), 64'(read_data), 64'(vecs[i].exp_rd));
            if (i == 0) begin
                check("store word0", 64'(sram_mem[0]), 64'h0BEEF);
                check("store word1", 64'(sram_mem[1]), 64'h0DEAD);
                check("store word0 we", 64'(we_cnt[0]), 64'(AC - 1));
                check("store word1 we", 64'(we_cnt[1]), 64'(AC - 1));
            end
            if (i == 2) begin
                check("store word6", 64'(sram_mem[6]), 64'h5678);
                check("store word7", 64'(sram_mem[7]), 64'h1234);
            end
        end

        for (int i = 0; i < 40; i++) begin
            int          op;
            int          word;
            logic [31:0] a;
            op   = int'($urandom_range(0, 2));
            word = int'($urandom_range(0, 12));
            a    = 32'd1024 + 32'(word * 4) + 32'($urandom_range(0, 3));
            run_access(op != 1, op != 0, a, $urandom, $sformatf("rnd%0d", i));
            check($sformatf("rnd%0d read_data", i), 64'(read_data), 64'(ref_last_read));
        end

        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        last_rise = -1;
        @(negedge clk);
        begin
            logic [SRAM_DEFAULT_ADDR_W-1:0] addr0;
            addr0 = sram_addr;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                check($sformatf("idle%0d", i), 64'({ready, sram_we_n, sram_oe_n, sram_addr}),
                      64'({3'b111, addr0}));
            end
        end

        // Abort a read in its HIGH half.
        @(posedge clk); #1;
        mem_r_en = 1'b1; address = 32'd1024;
        repeat (AC + 2) @(negedge clk);
        check("mid-read oe_n", 64'(sram_oe_n), 64'd0);
        rst = 1'b0; #1;
        check("abort read we_n", 64'(sram_we_n), 64'd1);
        check("abort read oe_n", 64'(sram_oe_n), 64'd1);
        check("abort read addr", 64'(sram_addr), 64'd0);
        check("abort read read_data", 64'(read_data), 64'd0);
        mem_r_en = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("after abort ready", 64'(ready), 64'd1);
        check("after abort read_data", 64'(read_data), 64'd0);

        // Abort a write while the strobe is low (word 15 is never read back).
        @(posedge clk); #1;
        mem_w_en = 1'b1; address = 32'd1084; write_data = 32'hFFFF0000;
        repeat (3) @(negedge clk);
        check("mid-write we_n", 64'(sram_we_n), 64'd0);
        rst = 1'b0; #1;
        check("abort write we_n", 64'(sram_we_n), 64'd1);
        check("abort write oe_n", 64'(sram_oe_n), 64'd1);
        mem_w_en = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("after write abort ready", 64'(ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1);
    end

endmodule
